// File: rtl/l2_pkg.sv
// Shared L2 snoop definitions: geometry, bus op codes, MESI/snoop-result encodings and FSM states.
package l2_pkg;

  localparam int BYTE_SELECT = 6;
  localparam int INDEX_BITS  = 14;
  localparam int TAG_BITS    = 12;
  localparam int LINE_SIZE   = 512;
  localparam int WAYS        = 8;
  localparam int ADDR_BITS   = TAG_BITS + INDEX_BITS + BYTE_SELECT;
  localparam int WAY_BITS    = $clog2(WAYS);

  localparam logic [7:0] OP_READ  = 8'h52;  // "R"
  localparam logic [7:0] OP_WRITE = 8'h57;  // "W"
  localparam logic [7:0] OP_RFO   = 8'h4D;  // "M"
  localparam logic [7:0] OP_INV   = 8'h49;  // "I"

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'b00,
    SNP_HIT   = 2'b01,
    SNP_HITM  = 2'b10
  } snoop_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESPOND,
    ST_WRITEBACK
  } state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_RFO) || (op == OP_INV);
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// Snoop responder signal bundle: shared-bus snoop, tag lookup, MESI update, writeback and stats.
interface snoop_responder_if;
  import l2_pkg::*;

  logic                  bus_valid;
  logic [7:0]            bus_op;
  logic [ADDR_BITS-1:0]  bus_addr;
  logic                  bus_ready;

  logic                  lk_req;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_ack;
  logic                  lk_hit;
  logic [WAY_BITS-1:0]   lk_way;
  mesi_t                 lk_mesi;
  logic [LINE_SIZE-1:0]  lk_data;

  logic                  upd_en;
  logic [INDEX_BITS-1:0] upd_index;
  logic [WAY_BITS-1:0]   upd_way;
  mesi_t                 upd_mesi;

  logic                  snoop_valid;
  snoop_res_t            snoop_result;

  logic                  wb_valid;
  logic [ADDR_BITS-1:0]  wb_addr;
  logic [LINE_SIZE-1:0]  wb_data;
  logic                  wb_ready;

  logic                  op_err;
  logic [31:0]           hit_count;
  logic [31:0]           hitm_count;

  // slave: the responder itself; master: the shared bus and cache arrays around it
  modport slave (
    input  bus_valid, bus_op, bus_addr,
    output bus_ready,
    output lk_req, lk_index, lk_tag,
    input  lk_ack, lk_hit, lk_way, lk_mesi, lk_data,
    output upd_en, upd_index, upd_way, upd_mesi,
    output snoop_valid, snoop_result,
    output wb_valid, wb_addr, wb_data,
    input  wb_ready,
    output op_err, hit_count, hitm_count
  );

  modport master (
    output bus_valid, bus_op, bus_addr,
    input  bus_ready,
    input  lk_req, lk_index, lk_tag,
    output lk_ack, lk_hit, lk_way, lk_mesi, lk_data,
    input  upd_en, upd_index, upd_way, upd_mesi,
    input  snoop_valid, snoop_result,
    input  wb_valid, wb_addr, wb_data,
    output wb_ready,
    input  op_err, hit_count, hitm_count
  );

endinterface

// File: rtl/snoop_policy.sv
// Combinational snoop policy: maps (op, current MESI) to snoop result, next MESI, writeback and error.
module snoop_policy
  import l2_pkg::*;
(
  input  logic [7:0] i_op,
  input  mesi_t      i_mesi,
  output snoop_res_t o_result,
  output mesi_t      o_new_mesi,
  output logic       o_writeback,
  output logic       o_err
);

  always_comb begin
    o_result    = SNP_NOHIT;
    o_new_mesi  = i_mesi;
    o_writeback = 1'b0;
    o_err       = 1'b0;
    case (i_op)
      OP_READ: begin
        case (i_mesi)
          MESI_M: begin
            o_result    = SNP_HITM;
            o_new_mesi  = MESI_S;
            o_writeback = 1'b1;
          end
          MESI_E, MESI_S: begin
            o_result   = SNP_HIT;
            o_new_mesi = MESI_S;
          end
          default: ;
        endcase
      end
      OP_WRITE, OP_RFO: begin
        case (i_mesi)
          MESI_M: begin
            o_result    = SNP_HITM;
            o_new_mesi  = MESI_I;
            o_writeback = 1'b1;
          end
          MESI_E, MESI_S: begin
            o_result   = SNP_HIT;
            o_new_mesi = MESI_I;
          end
          default: ;
        endcase
      end
      OP_INV: begin
        // An invalidate aimed at an owned line is a protocol error; the line is left untouched
        case (i_mesi)
          MESI_S: begin
            o_result   = SNP_HIT;
            o_new_mesi = MESI_I;
          end
          MESI_E, MESI_M: o_err = 1'b1;
          default: ;
        endcase
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: looks up snooped addresses, answers NOHIT/HIT/HITM, updates MESI and writes back dirty lines.
module snoop_responder
  import l2_pkg::*;
(
  input logic          clock,
  input logic          reset_n,
  snoop_responder_if.slave bus
);

  state_t                r_state;
  logic [7:0]            r_op;
  logic [TAG_BITS-1:0]   r_tag;
  logic [INDEX_BITS-1:0] r_index;
  logic [WAY_BITS-1:0]   r_way;
  logic [LINE_SIZE-1:0]  r_line;
  logic                  r_bus_ready;
  logic                  r_lk_req;
  logic                  r_upd_en;
  mesi_t                 r_upd_mesi;
  logic                  r_snoop_valid;
  snoop_res_t            r_snoop_result;
  logic                  r_wb_pending;
  logic                  r_wb_valid;
  logic                  r_op_err;
  logic [31:0]           r_hit_count;
  logic [31:0]           r_hitm_count;

  logic       w_accept;
  logic [7:0] w_pol_op;
  mesi_t      w_pol_mesi;
  snoop_res_t w_pol_result;
  mesi_t      w_pol_new;
  logic       w_pol_wb;
  logic       w_pol_err;
  logic       w_unused;

  assign w_accept = bus.bus_valid & r_bus_ready;
  assign w_unused = &{1'b0, bus.bus_addr[BYTE_SELECT-1:0]};

  // One policy instance serves both the illegal-op shortcut in IDLE and the lookup result in LOOKUP
  always_comb begin
    w_pol_op   = r_op;
    w_pol_mesi = MESI_I;
    if (r_state == ST_IDLE) begin
      w_pol_op = bus.bus_op;
    end else if (bus.lk_hit) begin
      w_pol_mesi = bus.lk_mesi;
    end
  end

  snoop_policy u_policy (
    .i_op        (w_pol_op),
    .i_mesi      (w_pol_mesi),
    .o_result    (w_pol_result),
    .o_new_mesi  (w_pol_new),
    .o_writeback (w_pol_wb),
    .o_err       (w_pol_err)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_op           <= '0;
      r_tag          <= '0;
      r_index        <= '0;
      r_way          <= '0;
      r_line         <= '0;
      r_bus_ready    <= 1'b1;
      r_lk_req       <= 1'b0;
      r_upd_en       <= 1'b0;
      r_upd_mesi     <= MESI_I;
      r_snoop_valid  <= 1'b0;
      r_snoop_result <= SNP_NOHIT;
      r_wb_pending   <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_op_err       <= 1'b0;
      r_hit_count    <= '0;
      r_hitm_count   <= '0;
    end else begin
      r_upd_en      <= 1'b0;
      r_snoop_valid <= 1'b0;
      r_op_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= bus.bus_op;
            r_tag       <= bus.bus_addr[ADDR_BITS-1 -: TAG_BITS];
            r_index     <= bus.bus_addr[BYTE_SELECT +: INDEX_BITS];
            r_bus_ready <= 1'b0;
            if (is_legal_op(bus.bus_op)) begin
              r_lk_req <= 1'b1;
              r_state  <= ST_LOOKUP;
            end else begin
              r_snoop_valid  <= 1'b1;
              r_snoop_result <= w_pol_result;
              r_op_err       <= w_pol_err;
              r_wb_pending   <= 1'b0;
              r_state        <= ST_RESPOND;
            end
          end
        end
        ST_LOOKUP: begin
          if (bus.lk_ack) begin
            r_lk_req       <= 1'b0;
            r_way          <= bus.lk_way;
            r_line         <= bus.lk_data;
            r_snoop_valid  <= 1'b1;
            r_snoop_result <= w_pol_result;
            r_op_err       <= w_pol_err;
            r_upd_en       <= (w_pol_new != w_pol_mesi);
            r_upd_mesi     <= w_pol_new;
            r_wb_pending   <= w_pol_wb;
            if (w_pol_result == SNP_HIT && r_hit_count != '1) begin
              r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_pol_result == SNP_HITM && r_hitm_count != '1) begin
              r_hitm_count <= r_hitm_count + 32'd1;
            end
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (r_wb_pending) begin
            r_wb_valid <= 1'b1;
            r_state    <= ST_WRITEBACK;
          end else begin
            r_bus_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        ST_WRITEBACK: begin
          if (bus.wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_bus_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.bus_ready    = r_bus_ready;
  assign bus.lk_req       = r_lk_req;
  assign bus.lk_index     = r_index;
  assign bus.lk_tag       = r_tag;
  assign bus.upd_en       = r_upd_en;
  assign bus.upd_index    = r_index;
  assign bus.upd_way      = r_way;
  assign bus.upd_mesi     = r_upd_mesi;
  assign bus.snoop_valid  = r_snoop_valid;
  assign bus.snoop_result = r_snoop_result;
  assign bus.wb_valid     = r_wb_valid;
  assign bus.wb_addr      = {r_tag, r_index, {BYTE_SELECT{1'b0}}};
  assign bus.wb_data      = r_line;
  assign bus.op_err       = r_op_err;
  assign bus.hit_count    = r_hit_count;
  assign bus.hitm_count   = r_hitm_count;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder: expected responses queued at issue, checked by independent monitors.
module tb_snoop_responder;
  import l2_pkg::*;

  typedef struct {
    snoop_res_t            res;
    logic                  upd_en;
    mesi_t                 upd_mesi;
    logic                  err;
    logic [INDEX_BITS-1:0] idx;
    logic [WAY_BITS-1:0]   way;
  } snp_exp_t;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [LINE_SIZE-1:0] data;
    int                   len;  // 0: burst is cut short, length not checked
  } wb_exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  snoop_responder_if bus();

  snoop_responder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  snp_exp_t sb[$];
  wb_exp_t  wq[$];
  int n_checks = 0;
  int n_fail = 0;
  int ack_delay = 0;
  int wb_delay = 0;
  int lk_seen = 0;
  logic [INDEX_BITS-1:0] exp_idx = '0;
  logic [TAG_BITS-1:0]   exp_tag = '0;
  logic [LINE_SIZE-1:0]  d1;
  logic [LINE_SIZE-1:0]  d2;
  int sv_lat, rdy_lat, waited;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got no event within bound, expected event", name);
  endtask

  // Issue one snoop; optionally wait for completion and report latencies in cycles after acceptance
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input bit wait_done,
                       input bit aligned, output int o_sv, output int o_rdy, output int o_wait);
    if (!aligned) begin
      @(posedge clock);
      #1;
    end
    bus.bus_valid = 1'b1;
    bus.bus_op    = op;
    bus.bus_addr  = addr;
    o_wait = 0;
    o_sv   = 0;
    o_rdy  = 0;
    while (!bus.bus_ready && o_wait < 100) begin
      @(posedge clock);
      #1;
      o_wait++;
    end
    if (!bus.bus_ready) fail_event("accept_timeout");
    @(posedge clock);
    #1;
    bus.bus_valid = 1'b0;
    if (wait_done) begin
      for (int k = 1; k <= 100; k++) begin
        @(negedge clock);
        if (o_sv == 0 && bus.snoop_valid) o_sv = k;
        if (bus.bus_ready) begin
          o_rdy = k;
          break;
        end
      end
      if (o_rdy == 0) fail_event("done_timeout");
    end
  endtask

  // Tag-array model: answers lk_req after ack_delay cycles and checks the presented index/tag
  initial begin
    int cnt;
    cnt = 0;
    bus.lk_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.lk_ack) begin
        bus.lk_ack = 1'b0;
        cnt = 0;
      end else if (bus.lk_req) begin
        lk_seen++;
        if (cnt == ack_delay) begin
          bus.lk_ack = 1'b1;
          check("lk_index", bus.lk_index, exp_idx);
          check("lk_tag", bus.lk_tag, exp_tag);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Shared-bus writeback sink: raises wb_ready wb_delay cycles into a burst
  initial begin
    int cnt;
    cnt = 0;
    bus.wb_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.wb_ready) begin
        bus.wb_ready = 1'b0;
        cnt = 0;
      end else if (bus.wb_valid) begin
        if (cnt == wb_delay) bus.wb_ready = 1'b1;
        else cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // Snoop-response monitor
  initial begin
    snp_exp_t e;
    forever begin
      @(negedge clock);
      if (bus.snoop_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL snoop_unexpected: got result %0d, expected no response", bus.snoop_result);
        end else begin
          e = sb.pop_front();
          check("snoop_result", bus.snoop_result, e.res);
          check("op_err", bus.op_err, e.err);
          check("upd_en", bus.upd_en, e.upd_en);
          if (e.upd_en) begin
            check("upd_mesi", bus.upd_mesi, e.upd_mesi);
            check("upd_index", bus.upd_index, e.idx);
            check("upd_way", bus.upd_way, e.way);
          end
        end
      end
    end
  end

  // Writeback monitor
  initial begin
    wb_exp_t w;
    bit in_burst;
    int len;
    in_burst = 1'b0;
    len = 0;
    w = '{'0, '0, 0};
    forever begin
      @(negedge clock);
      if (bus.wb_valid === 1'b1) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          len = 1;
          if (wq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got wb_addr 'h%0h, expected no writeback", bus.wb_addr);
            w = '{'0, '0, 0};
          end else begin
            w = wq.pop_front();
            check("wb_addr", bus.wb_addr, w.addr);
            check("wb_data", bus.wb_data, w.data);
          end
        end else begin
          len++;
        end
      end else if (in_burst) begin
        in_burst = 1'b0;
        if (w.len != 0) check("wb_len", len, w.len);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    d1 = {16{32'hDEADBEEF}};
    d2 = {8{64'h0123_4567_89AB_CDEF}};
    bus.bus_valid = 1'b0;
    bus.bus_op    = 8'h00;
    bus.bus_addr  = '0;
    bus.lk_hit    = 1'b0;
    bus.lk_way    = '0;
    bus.lk_mesi   = MESI_I;
    bus.lk_data   = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_bus_ready", bus.bus_ready, 1'b1);
    check("rst_lk_req", bus.lk_req, 1'b0);
    check("rst_snoop_valid", bus.snoop_valid, 1'b0);
    check("rst_upd_en", bus.upd_en, 1'b0);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_op_err", bus.op_err, 1'b0);
    check("rst_hit_count", bus.hit_count, 32'd0);
    check("rst_hitm_count", bus.hitm_count, 32'd0);

    // Read hitting a Modified line: HITM, demote to S, 4-cycle writeback
    exp_idx = 14'h2F01; exp_tag = 12'h00A;
    bus.lk_hit = 1'b1; bus.lk_way = 3'd5; bus.lk_mesi = MESI_M; bus.lk_data = d1;
    ack_delay = 0; wb_delay = 3;
    sb.push_back('{SNP_HITM, 1'b1, MESI_S, 1'b0, 14'h2F01, 3'd5});
    wq.push_back('{32'h00ABC040, d1, 4});
    issue(OP_READ, 32'h00ABC040, 1'b1, 1'b0, sv_lat, rdy_lat, waited);
    check("r_m_snoop_lat", sv_lat, 2);
    check("r_m_ready_lat", rdy_lat, 7);
    check("r_m_hitm_count", bus.hitm_count, 32'd1);
    check("r_m_hit_count", bus.hit_count, 32'd0);

    // Read-for-ownership on Exclusive: HIT, invalidate, no writeback
    bus.lk_way = 3'd2; bus.lk_mesi = MESI_E;
    sb.push_back('{SNP_HIT, 1'b1, MESI_I, 1'b0, 14'h2F01, 3'd2});
    issue(OP_RFO, 32'h00ABC040, 1'b1, 1'b0, sv_lat, rdy_lat, waited);
    check("m_e_snoop_lat", sv_lat, 2);
    check("m_e_ready_lat", rdy_lat, 3);
    check("m_e_hit_count", bus.hit_count, 32'd1);

    // Invalidate on Modified: NOHIT, error, no state change
    bus.lk_mesi = MESI_M;
    sb.push_back('{SNP_NOHIT, 1'b0, MESI_I, 1'b1, 14'h2F01, 3'd2});
    issue(OP_INV, 32'h00ABC040, 1'b1, 1'b0, sv_lat, rdy_lat, waited);
    check("i_m_ready_lat", rdy_lat, 3);
    check("i_m_hit_count", bus.hit_count, 32'd1);

    // Illegal op "X": answered the next cycle without a lookup
    lk_seen = 0;
    sb.push_back('{SNP_NOHIT, 1'b0, MESI_I, 1'b1, '0, '0});
    issue(8'h58, 32'h00ABC040, 1'b1, 1'b0, sv_lat, rdy_lat, waited);
    check("x_snoop_lat", sv_lat, 1);
    check("x_ready_lat", rdy_lat, 2);
    check("x_lk_req_seen", lk_seen, 0);

    // Back-to-back ops with a slow lookup: second waits until the first returns to IDLE
    bus.lk_way = 3'd7; bus.lk_mesi = MESI_S; ack_delay = 5;
    sb.push_back('{SNP_HIT, 1'b0, MESI_S, 1'b0, 14'h2F01, 3'd7});
    sb.push_back('{SNP_HIT, 1'b1, MESI_I, 1'b0, 14'h2F01, 3'd7});
    issue(OP_READ, 32'h00ABC040, 1'b0, 1'b0, sv_lat, rdy_lat, waited);
    check("b2b_first_wait", waited, 0);
    issue(OP_WRITE, 32'h00ABC040, 1'b1, 1'b1, sv_lat, rdy_lat, waited);
    check("b2b_second_wait", waited, 7);
    check("b2b_snoop_lat", sv_lat, 7);
    check("b2b_ready_lat", rdy_lat, 8);
    check("b2b_hit_count", bus.hit_count, 32'd3);

    // Reset in the middle of a writeback burst
    exp_idx = 14'h115A; exp_tag = 12'h123;
    bus.lk_way = 3'd1; bus.lk_mesi = MESI_M; bus.lk_data = d2;
    ack_delay = 0; wb_delay = 50;
    sb.push_back('{SNP_HITM, 1'b1, MESI_S, 1'b0, 14'h115A, 3'd1});
    wq.push_back('{32'h12345680, d2, 0});
    issue(OP_READ, 32'h12345680, 1'b0, 1'b0, sv_lat, rdy_lat, waited);
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.wb_valid) break;
    end
    if (!bus.wb_valid) fail_event("wb_start_timeout");
    check("wbrst_hitm_before", bus.hitm_count, 32'd2);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("wbrst_wb_valid", bus.wb_valid, 1'b0);
    check("wbrst_bus_ready", bus.bus_ready, 1'b1);
    check("wbrst_hit_count", bus.hit_count, 32'd0);
    check("wbrst_hitm_count", bus.hitm_count, 32'd0);
    repeat (3) @(negedge clock);
    check("wbrst_wb_stays_low", bus.wb_valid, 1'b0);

    check("sb_drained", sb.size(), 0);
    check("wq_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameters SHALL be: BYTE_SELECT 6 (line-offset bits); INDEX_BITS 14 (set-index bits); TAG_BITS 12 (tag bits); LINE_SIZE 512 (line width); WAYS 8 (associativity); ADDR_BITS = TAG_BITS+INDEX_BITS+BYTE_SELECT (32).
REQ-002 clock  in  1  sole clock; all logic on rising edge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 bus_valid  in  1  snooped shared-bus operation present.
REQ-005 bus_op  in  8  ASCII op code: "R" read, "W" write, "M" read-for-ownership, "I" invalidate.
REQ-006 bus_addr  in  ADDR_BITS  snooped address {tag,index,offset}.
REQ-007 bus_ready  out  1  responder can accept an operation.
REQ-008 lk_req / lk_index / lk_tag  out  1 / INDEX_BITS / TAG_BITS  tag-array lookup request.
REQ-009 lk_ack / lk_hit / lk_way / lk_mesi / lk_data  in  1 / 1 / clog2(WAYS) / 2 / LINE_SIZE  lookup result, valid only while lk_ack=1.
REQ-010 upd_en / upd_index / upd_way / upd_mesi  out  1 / INDEX_BITS / clog2(WAYS) / 2  MESI state write-back into the cache.
REQ-011 snoop_valid / snoop_result  out  1 / 2  snoop response; NOHIT=00, HIT=01, HITM=10.
REQ-012 wb_valid / wb_addr / wb_data / wb_ready  out / out / out / in  1 / ADDR_BITS / LINE_SIZE / 1  modified-line writeback to the shared bus.
REQ-013 op_err  out  1  one-cycle pulse on an illegal op or protocol violation.
REQ-014 hit_count / hitm_count  out  32 / 32  saturating statistics.

Function
REQ-015 MESI encoding SHALL be I=0, S=1, E=2, M=3; lk_hit=0 SHALL be treated as I.
REQ-016 FSM states SHALL be IDLE, LOOKUP, RESPOND, WRITEBACK.
REQ-017 bus_ready SHALL be 1 only in IDLE; an op is accepted on bus_valid&bus_ready; bus_op and bus_addr SHALL be latched at acceptance.
REQ-018 IDLE->LOOKUP on acceptance of a legal op; lk_req SHALL assert from the next cycle and hold, with index/tag stable, until lk_ack is sampled.
REQ-019 LOOKUP->RESPOND on lk_ack; lk_way, lk_mesi and lk_data SHALL be captured in that cycle.
REQ-020 In RESPOND (exactly 1 cycle), snoop_valid SHALL be 1 and upd_en SHALL be 1 iff the new state differs from the captured state.
REQ-021 "R" policy: M->HITM,S,writeback; E->HIT,S; S->HIT,S; I->NOHIT, no update.
REQ-022 "W" and "M" policy: M->HITM,I,writeback; E or S->HIT,I; I->NOHIT.
REQ-023 "I" policy: S->HIT,I; I->NOHIT; E or M->NOHIT, no update, op_err pulse in RESPOND.
REQ-024 Illegal op code SHALL be accepted; the next cycle SHALL give snoop_valid=1, NOHIT and op_err=1, with no lookup, then return to IDLE.
REQ-025 RESPOND->WRITEBACK when the result is HITM, else ->IDLE.
REQ-026 In WRITEBACK, wb_valid SHALL hold with wb_addr={tag,index,BYTE_SELECT'0} and wb_data=captured line until wb_ready is sampled 1, then ->IDLE.
REQ-027 hit_count SHALL increment on each HIT response and hitm_count on each HITM response; both SHALL saturate at 2^32-1.
REQ-028 Minimum latency SHALL be: accept at N, lk_req at N+1, lk_ack at N+1, snoop_valid at N+2, bus_ready at N+3 (non-HITM).

Reset
REQ-029 With reset_n=0 at a clock edge, the FSM SHALL go to IDLE, all outputs SHALL be 0 except bus_ready=1, and both counters SHALL be 0.
REQ-030 Reset during LOOKUP or WRITEBACK SHALL abandon the operation with no update and no further wb_valid.

Structure
REQ-031 Shared package l2_pkg SHALL hold the op-code constants, the MESI enum, the snoop-result enum and the FSM state typedef.
REQ-032 The next-state/result policy SHALL be a combinational sub-module, snoop_policy (op, mesi -> result, new_mesi, writeback, err).

Verification
REQ-033 "R" to 0x00ABC040, lk_hit=1, mesi=M, wb_ready delayed 3 cycles -> HITM, upd_mesi=S, wb_addr=0x00ABC040, wb_valid held 4 cycles, hitm_count=1.
REQ-034 "M" with mesi=E -> HIT, upd_mesi=I, no wb_valid, hit_count=1.
REQ-035 "I" with mesi=M -> NOHIT, op_err pulse, upd_en=0.
REQ-036 bus_op=0x58 ("X") -> NOHIT next cycle, op_err=1, lk_req never asserted.
REQ-037 Back-to-back bus_valid with lk_ack delayed 5 cycles -> bus_ready=0 throughout, second op accepted only after return to IDLE.
REQ-038 reset_n=0 during WRITEBACK -> wb_valid=0 next cycle, bus_ready=1, counters=0.
